core_lsu_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the execution unit's load/store datapath and the data-memory bus.
- Converts the single-cycle address/data produced in EX into a req/gnt/rvalid bus transaction.
- Stalls the core while the transaction is outstanding and returns registered load data plus completion and error strobes.
- Lets the data memory be a slow or shared SRAM/bus slave instead of a combinational array.

---
 rtl/core_lsu_ctrl_pkg.sv | 14 +
 rtl/core_lsu_ctrl_timeout.sv | 22 ++
 rtl/core_lsu_ctrl.sv | 109 ++++++++++
 tb/tb_core_lsu_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_ctrl_pkg.sv
// core_lsu_ctrl_pkg: shared state encoding and default widths for the load/store sequencer
package core_lsu_ctrl_pkg;
  localparam int DEF_MEM_ADDR_WIDTH = 10;
  localparam int REG_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int STATE_WIDTH = 3;
  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } lsu_state_e;
endpackage

// File: rtl/core_lsu_ctrl_timeout.sv
// core_lsu_ctrl_timeout: saturating cycle counter flagging the last allowed cycle of a bus access
module core_lsu_ctrl_timeout
  import core_lsu_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_WIDTH-1:0] cnt;
  // count outstanding cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  // the counter reaches LIMIT at the end of this cycle, so this is the last cycle allowed
  assign tc = cnt >= CNT_WIDTH'(LIMIT - 1);
endmodule

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl: turns an EX-stage load/store into a req/gnt/rvalid bus transaction and stalls the core meanwhile
module core_lsu_ctrl
  import core_lsu_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  input  logic                      is_loadstore_i,
  input  logic                      is_store_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      flush_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      stall_o,
  output logic [DATA_WIDTH-1:0]     load_data_o,
  output logic                      done_o,
  output logic                      err_o
);
  lsu_state_e state, state_n;
  logic req_n, we_n, flushed, flushed_n, tc, start, kill;
  logic [MEM_ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, ld_n;
  assign start = ex_valid_i & is_loadstore_i & ~flush_i;
  assign kill = flushed | flush_i;
  core_lsu_ctrl_timeout #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en(state == REQ || state == WAIT_RSP),
    .tc(tc)
  );
  // register state and every bus/core-facing output; pulses follow the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      load_data_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      flushed     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req_o   <= req_n;
      mem_we_o    <= we_n;
      mem_addr_o  <= addr_n;
      mem_wdata_o <= wdata_n;
      load_data_o <= ld_n;
      done_o      <= state_n == DONE;
      err_o       <= state_n == ERR;
      flushed     <= flushed_n;
    end
  // next state and next register values; grant beats flush and timeout, rvalid beats timeout
  always_comb begin
    state_n   = state;
    req_n     = mem_req_o;
    we_n      = mem_we_o;
    addr_n    = mem_addr_o;
    wdata_n   = mem_wdata_o;
    ld_n      = load_data_o;
    flushed_n = flushed;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = start;
        if (start) begin
          state_n   = REQ;
          req_n     = 1'b1;
          we_n      = is_store_i;
          addr_n    = addr_i;
          wdata_n   = wdata_i;
          flushed_n = 1'b0;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (mem_gnt_i) begin
          req_n   = 1'b0;
          state_n = mem_we_o ? DONE : WAIT_RSP;
        end else if (flush_i || tc) begin
          req_n   = 1'b0;
          state_n = flush_i ? IDLE : ERR;
        end
      end
      WAIT_RSP: begin
        stall_o   = 1'b1;
        flushed_n = kill;
        if (mem_rvalid_i) begin
          state_n = kill ? IDLE : DONE;
          ld_n    = kill ? load_data_o : mem_rdata_i;
        end else if (tc) state_n = ERR;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl: directed stimulus with a completion scoreboard checked by an independent monitor
module tb_core_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid = 1'b0, is_ls = 1'b0, is_store = 1'b0, flush = 1'b0;
  logic [9:0] addr = '0;
  logic [31:0] wdata = '0, rdata = '0;
  logic gnt = 1'b0, rvalid = 1'b0;
  logic mem_req, mem_we, stall, done, err;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, load_data;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  core_lsu_ctrl #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid_i(ex_valid),
    .is_loadstore_i(is_ls),
    .is_store_i(is_store),
    .addr_i(addr),
    .wdata_i(wdata),
    .flush_i(flush),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata),
    .stall_o(stall),
    .load_data_o(load_data),
    .done_o(done),
    .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic st, input logic [9:0] a, input logic [31:0] d);
    ex_valid = 1'b1;
    is_ls = 1'b1;
    is_store = st;
    addr = a;
    wdata = d;
  endtask
  task automatic idle_in();
    ex_valid = 1'b0;
    is_ls = 1'b0;
    is_store = 1'b0;
  endtask
  // every done/err pulse must match the oldest expected completion
  always @(negedge clk) begin
    exp_t e;
    if (done || err) begin
      if (q.size() == 0) chk("unexpected_pulse", {done, err}, 2'b00);
      else begin
        e = q.pop_front();
        chk("completion", {err, done, load_data}, {e.is_err, !e.is_err, e.data});
      end
    end
  end
  initial begin
    tick();
    tick();
    chk("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, load_data, done, err, stall}, '0);
    rst = 1'b0;
    tick();
    // load 0x05, immediate grant, rvalid one cycle later
    start(1'b0, 10'h005, 32'h0);
    q.push_back('{1'b0, 32'hDEADBEEF});
    #1 chk("ld_c1_stall_req", {stall, mem_req}, 2'b10);
    tick();
    idle_in();
    gnt = 1'b1;
    #1 chk("ld_c2_req", {stall, mem_req, mem_we, mem_addr}, {3'b110, 10'h005});
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hDEADBEEF;
    #1 chk("ld_c3_wait", {stall, mem_req}, 2'b10);
    tick();
    rvalid = 1'b0;
    #1 chk("ld_c4_done", {stall, done, load_data}, {2'b01, 32'hDEADBEEF});
    tick();
    chk("ld_after", {stall, done, mem_req}, 3'b000);
    // store 0x12345678 to 0x3FF, grant in the 4th request cycle (also the last before timeout)
    start(1'b1, 10'h3FF, 32'h12345678);
    q.push_back('{1'b0, 32'hDEADBEEF});
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_in();
      gnt = (i == 3);
      #1 chk("st_req_stable", {stall, mem_req, mem_we, mem_addr, mem_wdata}, {3'b111, 10'h3FF, 32'h12345678});
    end
    tick();
    gnt = 1'b0;
    #1 chk("st_done", {stall, done, mem_req, load_data}, {3'b010, 32'hDEADBEEF});
    tick();
    // load that is never granted times out after 4 request cycles
    start(1'b0, 10'h010, 32'h0);
    q.push_back('{1'b1, 32'hDEADBEEF});
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_in();
      #1 chk("to_req_held", {stall, mem_req, err}, 3'b110);
    end
    tick();
    chk("to_err", {err, done, mem_req, stall, load_data}, {4'b1000, 32'hDEADBEEF});
    tick();
    chk("to_after", {err, stall}, 2'b00);
    // flush while the request is still ungranted
    start(1'b0, 10'h020, 32'h0);
    tick();
    idle_in();
    flush = 1'b1;
    #1 chk("fl_req", {stall, mem_req}, 2'b11);
    tick();
    flush = 1'b0;
    #1 chk("fl_dropped", {stall, mem_req, done}, 3'b000);
    tick();
    // flush while waiting for read data: response consumed silently
    start(1'b0, 10'h021, 32'h0);
    tick();
    idle_in();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    flush = 1'b1;
    #1 chk("flw_stall", stall, 1'b1);
    tick();
    flush = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hAAAA5555;
    tick();
    rvalid = 1'b0;
    #1 chk("flw_no_update", {stall, done, load_data}, {2'b00, 32'hDEADBEEF});
    tick();
    // reset in WAIT_RSP; the late rvalid must be ignored
    start(1'b0, 10'h030, 32'h0);
    tick();
    idle_in();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst = 1'b1;
    #1 chk("rst_mid", {mem_req, mem_we, mem_addr, mem_wdata, load_data, done, err, stall}, '0);
    tick();
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hBADBAD00;
    tick();
    rvalid = 1'b0;
    #1 chk("rst_late_rvalid", {load_data, mem_req, done, stall}, '0);
    start(1'b0, 10'h031, 32'h0);
    q.push_back('{1'b0, 32'hCAFEF00D});
    tick();
    idle_in();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hCAFEF00D;
    tick();
    rvalid = 1'b0;
    #1 chk("rst_next_load", {done, load_data}, {1'b1, 32'hCAFEF00D});
    tick();
    // back-to-back load then store with ex_valid held high
    start(1'b0, 10'h040, 32'h0);
    q.push_back('{1'b0, 32'h11223344});
    q.push_back('{1'b0, 32'h11223344});
    tick();
    gnt = 1'b1;
    #1 chk("b2b_ld_req", {mem_req, mem_we, mem_addr}, {2'b10, 10'h040});
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h11223344;
    tick();
    rvalid = 1'b0;
    start(1'b1, 10'h041, 32'h55667788);
    #1 chk("b2b_ld_done", {done, stall, mem_req}, 3'b100);
    tick();
    chk("b2b_idle_gap", {stall, mem_req, done}, 3'b100);
    tick();
    gnt = 1'b1;
    #1 chk("b2b_st_req", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 10'h041, 32'h55667788});
    tick();
    gnt = 1'b0;
    idle_in();
    #1 chk("b2b_st_done", {done, stall, load_data}, {2'b10, 32'h11223344});
    tick();
    chk("b2b_after", {stall, mem_req, done}, 3'b000);
    tick();
    tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
